mux_sel_sched: RTL and testbench
================================

# mux_sel_sched

Power-aware scheduler that time-shares the 2-bit `mux_2to1` datapath between two requesters, A and B. It drives the mux `sel` line and a one-deep registered output with a valid/ready handshake. It keeps `sel` stable for a minimum dwell window and bounds bursts so that neither side starves. It also counts `sel` transitions for switching-activity monitoring.

## Interface
- `MIN_DWELL`, default 4: minimum number of cycles `sel` must stay unchanged before it may toggle again (range 1–15).
- `MAX_BURST`, default 8: number of beats accepted from one side before the scheduler must switch, if the other side is waiting (range 1–15).
- `clk` in 1: single clock; everything is updated on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_a` in 1: requester A has a beat; it holds `req_a` and `data_a` until `ack_a`.
- `data_a` in 2: requester A operand.
- `ack_a` out 1: A's beat is accepted this cycle (combinational).
- `req_b`, `data_b`, `ack_b`: the same for requester B.
- `sel` out 1: registered mux select; 1 selects A, 0 selects B.
- `out_valid` out 1: `out_data` holds a beat.
- `out_ready` in 1: the downstream consumer accepts `out_data`.
- `out_data` out 2: registered mux result.
- `out_src` out 1: source of `out_data` (1 = A).
- `toggle_cnt` out 8: saturating count of `sel` transitions.

## Operation
- The FSM has three states: IDLE, SERVE and TURN. The current side is the side named by `sel`; the other side is its complement.
- `out_free` = !`out_valid` | `out_ready`.
- `dwell_cnt` (4 bits):
  - Cleared on every `sel` toggle.
  - Otherwise increments every cycle, saturating at `MIN_DWELL`.
- `burst_cnt` (4 bits):
  - Increments on each ack, saturating at `MAX_BURST`.
  - Cleared on TURN entry.
- `may_switch` = other side's req & (`dwell_cnt` == `MIN_DWELL`) & (!current side's req | `burst_cnt` == `MAX_BURST`).
- IDLE:
  - If the current side requests, go to SERVE.
  - Else if `may_switch`, go to TURN.
  - Else stay in IDLE. `sel` holds its value, so no toggle occurs without demand.
- SERVE:
  - If `may_switch`, go to TURN. No ack is issued in that cycle.
  - Else if neither side requests, go to IDLE.
  - Else stay in SERVE.
  - Ack rule: the current side's ack = SERVE & current req & `out_free` & !`may_switch`.
- TURN:
  - `sel` toggled on the edge entering TURN.
  - One bubble cycle with no acks, then unconditionally go to SERVE.
  - If the new side has dropped its req, SERVE goes to IDLE on the following cycle.
- On any ack, the next edge loads:
  - `out_data` ← (`sel` ? `data_a` : `data_b`)
  - `out_src` ← `sel`
  - `out_valid` ← 1
- If `out_ready` is high and there is no ack, `out_valid` ← 0. If `out_ready` and an ack occur in the same cycle, the register reloads and `out_valid` stays 1.
- `toggle_cnt` increments on every `sel` toggle and saturates at 255.
- Acks are never asserted for both sides at once, and never asserted for a side whose `req` is low.

## Timing
- Reset values:
  - state IDLE, `sel` 0, `dwell_cnt` = `MIN_DWELL` (so the first switch is not delayed), `burst_cnt` 0.
  - `out_valid` 0, `out_data` 0, `out_src` 0, `toggle_cnt` 0.
  - `ack_a` and `ack_b` are 0 during reset.
- Reset mid-operation discards any held `out_data` beat and any pending switch. Reset has priority over all other updates.
- Latency, same side, from IDLE: req seen in cycle n → SERVE in n+1 → ack in n+1 → `out_valid` in n+2.
- Latency, other side, from IDLE with dwell satisfied: req in n → `sel` toggles at n+1 (TURN) → ack in n+2 → `out_valid` in n+3.
- Back-to-back throughput is 1 beat/cycle while `out_ready` is held high.
- With `out_ready` low and `out_valid` high, acks stall; `sel`, counters and state still evolve.
- Simultaneous `req_a` and `req_b` in IDLE: the current side wins, so there is no toggle.
- Minimum spacing between two `sel` toggles is `MIN_DWELL` cycles.

## Test plan
- **Single requester.** After reset, `req_b`=1, `data_b`=2'b10, `out_ready`=1 for 3 beats → `ack_b` pulses in cycles 1–3; `out_data`=2'b10 and `out_src`=0 in cycles 2–4; `sel` stays 0; `toggle_cnt`=0.
- **Switch on A.** After reset, only `req_a`=1, `data_a`=2'b01 → `sel`=1 at cycle 1; `ack_a` at cycle 2; `out_data`=2'b01 and `out_src`=1 at cycle 3; `toggle_cnt`=1.
- **Burst fairness.** `req_a` and `req_b` held high, `out_ready`=1, defaults → exactly 8 consecutive acks per side, one TURN bubble between bursts, and `sel` toggles every 10 cycles.
- **Dwell.** `MIN_DWELL`=4: B served for 1 beat, then `req_b` drops and `req_a` rises at cycle 2 after a toggle → `sel` does not toggle until `dwell_cnt` reaches 4.
- **Backpressure.** `out_ready`=0 with `out_valid`=1 → no acks and `out_data` is stable. Raising `out_ready` gives an ack the same cycle and a new `out_data` on the next edge.
- **Reset mid-burst.** Assert `rst` for 1 cycle during an A burst with `out_valid`=1 → the next cycle shows `out_valid`=0, `sel`=0, `toggle_cnt`=0, state IDLE, and no ack during reset.

Source files
------------

// File: rtl/mux_sel_sched.sv
// mux_sel_sched: dwell/burst-aware scheduler sharing a 2-bit mux between requesters A and B
module mux_sel_sched #(
   parameter int MIN_DWELL = 4,
   parameter int MAX_BURST = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic [1:0] data_a,
   output logic       ack_a,
   input  logic       req_b,
   input  logic [1:0] data_b,
   output logic       ack_b,
   output logic       sel,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_data,
   output logic       out_src,
   output logic [7:0] toggle_cnt
);
   typedef enum logic [1:0] {IDLE, SERVE, TURN} state_t;
   localparam logic [3:0] DWELL = 4'(MIN_DWELL);
   localparam logic [3:0] BURST = 4'(MAX_BURST);
   state_t state, state_nx;
   logic [3:0] dwell_cnt, burst_cnt;
   logic cur_req, oth_req, out_free, may_switch, ack, toggle;
   assign cur_req    = sel ? req_a : req_b;
   assign oth_req    = sel ? req_b : req_a;
   assign out_free   = !out_valid || out_ready;
   assign may_switch = oth_req && dwell_cnt == DWELL && (!cur_req || burst_cnt == BURST);
   // acks are suppressed while reset is held, whatever state the register still shows
   assign ack        = !rst && state == SERVE && cur_req && out_free && !may_switch;
   assign ack_a      = ack && sel;
   assign ack_b      = ack && !sel;
   assign toggle     = state != TURN && state_nx == TURN;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = cur_req ? SERVE : may_switch ? TURN : IDLE;
         SERVE:   state_nx = may_switch ? TURN : (req_a || req_b) ? SERVE : IDLE;
         default: state_nx = SERVE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= 1'b0;
         dwell_cnt  <= DWELL;
         burst_cnt  <= 4'd0;
         out_valid  <= 1'b0;
         out_data   <= 2'd0;
         out_src    <= 1'b0;
         toggle_cnt <= 8'd0;
      end else begin
         state <= state_nx;
         if (toggle) begin
            sel        <= !sel;
            dwell_cnt  <= 4'd0;
            burst_cnt  <= 4'd0;
            toggle_cnt <= toggle_cnt == 8'hff ? toggle_cnt : toggle_cnt + 8'd1;
         end else begin
            dwell_cnt <= dwell_cnt == DWELL ? dwell_cnt : dwell_cnt + 4'd1;
            burst_cnt <= (ack && burst_cnt != BURST) ? burst_cnt + 4'd1 : burst_cnt;
         end
         if (ack) begin
            out_data  <= sel ? data_a : data_b;
            out_src   <= sel;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux_sel_sched.sv
// tb_mux_sel_sched: directed scenarios with a beat scoreboard drained by an output monitor
module tb_mux_sel_sched;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_a = 1'b0, req_b = 1'b0, out_ready = 1'b1;
   logic [1:0] data_a = 2'd0, data_b = 2'd0;
   logic       ack_a, ack_b, sel, out_valid, out_src;
   logic [1:0] out_data;
   logic [7:0] toggle_cnt;
   int         checks = 0, errors = 0;
   logic [2:0] sb[$];
   logic [2:0] exp_beat;

   mux_sel_sched dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
      .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
      .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_src(out_src), .toggle_cnt(toggle_cnt)
   );

   always #5 clk = !clk;

   // a beat leaves the output register on every edge that sees valid & ready
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected src=%0d data=%0d", out_src, out_data);
         end else begin
            exp_beat = sb.pop_front();
            if ({out_src, out_data} !== exp_beat) begin
               errors++;
               $display("FAIL beat: got src=%0d data=%0d want src=%0d data=%0d",
                        out_src, out_data, exp_beat[2], exp_beat[1:0]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ((ack_a && ack_b) || (ack_a && !req_a) || (ack_b && !req_b)) begin
            errors++;
            $display("FAIL ack_rule: ack_a=%0d ack_b=%0d req_a=%0d req_b=%0d", ack_a, ack_b, req_a, req_b);
         end
      end
   end

   task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", n, a, e);
      end
   endtask

   task automatic c;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic src, input logic [1:0] d, input int n);
      for (int i = 0; i < n; i++) sb.push_back({src, d});
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req_a = 1'b1;
      req_b = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ack_a", ack_a, 0);
      chk("rst_ack_b", ack_b, 0);
      req_a = 1'b0;
      req_b = 1'b0;
      data_a = 2'd0;
      data_b = 2'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
   endtask

   initial begin
      do_reset;
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sel", sel, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_src", out_src, 0);
      chk("reset_toggle", toggle_cnt, 0);

      // single requester B, no switch needed
      do_reset;
      push(1'b0, 2'b10, 3);
      req_b = 1'b1;
      data_b = 2'b10;
      #1;
      chk("single_c0_ack_b", ack_b, 0);
      for (int i = 1; i <= 4; i++) begin
         c;
         if (i == 4) req_b = 1'b0;
         #1;
         chk("single_ack_b", ack_b, (i <= 3) ? 8'd1 : 8'd0);
         chk("single_sel", sel, 0);
         if (i >= 2) begin
            chk("single_out_valid", out_valid, 1);
            chk("single_out_data", out_data, 2'b10);
            chk("single_out_src", out_src, 0);
         end
      end
      chk("single_toggle", toggle_cnt, 0);

      // switch to A, then dwell holds the return to B
      do_reset;
      push(1'b1, 2'b01, 1);
      req_a = 1'b1;
      data_a = 2'b01;
      c; #1;
      chk("switch_c1_sel", sel, 1);
      chk("switch_c1_ack_a", ack_a, 0);
      chk("switch_c1_toggle", toggle_cnt, 1);
      c; #1;
      chk("switch_c2_ack_a", ack_a, 1);
      c;
      req_a = 1'b0;
      req_b = 1'b1;
      data_b = 2'b11;
      push(1'b0, 2'b11, 1);
      #1;
      chk("switch_c3_out_data", out_data, 2'b01);
      chk("switch_c3_out_src", out_src, 1);
      for (int i = 3; i <= 5; i++) begin
         if (i > 3) begin c; #1; end
         chk("dwell_sel_held", sel, 1);
         chk("dwell_no_ack_b", ack_b, 0);
      end
      c; #1;
      chk("dwell_c6_sel", sel, 0);
      chk("dwell_c6_ack_b", ack_b, 0);
      chk("dwell_c6_toggle", toggle_cnt, 2);
      c; #1;
      chk("dwell_c7_ack_b", ack_b, 1);
      c;
      req_b = 1'b0;
      #1;
      chk("dwell_c8_out_data", out_data, 2'b11);
      chk("dwell_c8_out_src", out_src, 0);

      // burst fairness with both sides requesting
      do_reset;
      data_a = 2'b01;
      data_b = 2'b10;
      push(1'b0, 2'b10, 8);
      push(1'b1, 2'b01, 8);
      push(1'b0, 2'b10, 8);
      req_a = 1'b1;
      req_b = 1'b1;
      for (int i = 1; i <= 29; i++) begin
         c;
         if (i == 29) begin req_a = 1'b0; req_b = 1'b0; end
         #1;
         chk("fair_ack_a", ack_a, (i >= 11 && i <= 18) ? 8'd1 : 8'd0);
         chk("fair_ack_b", ack_b, ((i >= 1 && i <= 8) || (i >= 21 && i <= 28)) ? 8'd1 : 8'd0);
         chk("fair_sel", sel, (i >= 10 && i < 20) ? 8'd1 : 8'd0);
      end
      chk("fair_toggle", toggle_cnt, 2);

      // backpressure stalls acks and holds the output
      do_reset;
      out_ready = 1'b0;
      req_b = 1'b1;
      data_b = 2'b11;
      push(1'b0, 2'b11, 1);
      push(1'b0, 2'b01, 1);
      c; #1;
      chk("bp_c1_ack_b", ack_b, 1);
      c;
      data_b = 2'b01;
      #1;
      chk("bp_c2_ack_b", ack_b, 0);
      chk("bp_c2_out_valid", out_valid, 1);
      chk("bp_c2_out_data", out_data, 2'b11);
      c; #1;
      chk("bp_c3_ack_b", ack_b, 0);
      chk("bp_c3_out_data", out_data, 2'b11);
      c;
      out_ready = 1'b1;
      #1;
      chk("bp_c4_ack_b", ack_b, 1);
      c;
      req_b = 1'b0;
      #1;
      chk("bp_c5_out_data", out_data, 2'b01);
      chk("bp_c5_out_valid", out_valid, 1);
      c; #1;
      chk("bp_c6_out_valid", out_valid, 0);

      // reset in the middle of an A burst
      do_reset;
      req_a = 1'b1;
      data_a = 2'b10;
      push(1'b1, 2'b10, 3);
      repeat (4) c;
      c;
      rst = 1'b1;
      #1;
      chk("mid_c5_out_valid", out_valid, 1);
      chk("mid_c5_ack_a", ack_a, 0);
      c;
      rst = 1'b0;
      req_a = 1'b0;
      req_b = 1'b1;
      data_b = 2'b01;
      sb.delete();
      push(1'b0, 2'b01, 1);
      #1;
      chk("mid_c6_out_valid", out_valid, 0);
      chk("mid_c6_sel", sel, 0);
      chk("mid_c6_toggle", toggle_cnt, 0);
      chk("mid_c6_ack_b", ack_b, 0);
      c; #1;
      chk("mid_c7_ack_b", ack_b, 1);
      c;
      req_b = 1'b0;
      #1;
      chk("mid_c8_out_data", out_data, 2'b01);
      chk("mid_c8_out_src", out_src, 0);

      repeat (3) c;
      chk("sb_drained", 8'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
